// File: rtl/mode_code_sequencer.sv
// Mode-code driven beat sequencer: direction, step and overflow handling
// come from a 3-bit mode code latched when a run is accepted.
module mode_code_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [WIDTH-1:0] len,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             sat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

  state_t           state_q;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] beat_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic             sat_q;

  logic [WIDTH:0]   step_w;
  logic [WIDTH:0]   ext_w;
  logic [WIDTH-1:0] next_d;
  logic             clip_d;
  logic             last_w;

  // One extra bit exposes carry (up) or borrow (down) of the step.
  always_comb begin
    step_w = mode_q[1] ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    ext_w  = '0;
    next_d = '0;
    clip_d = 1'b0;
    if (mode_q[2]) ext_w = {1'b0, count_q} + step_w;
    else           ext_w = {1'b0, count_q} - step_w;
    if (ext_w[WIDTH] && !mode_q[0]) begin
      next_d = mode_q[2] ? MAXV : '0;
      clip_d = 1'b1;
    end else begin
      next_d = ext_w[WIDTH-1:0];
    end
  end

  assign last_w = (beat_q == len_q - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          if (start) begin
            mode_q <= mode;
            len_q  <= len;
            sat_q  <= 1'b0;
            beat_q <= '0;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q <= S_RUN;
              valid_q <= 1'b1;
              count_q <= mode[2] ? '0 : MAXV;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_w) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            beat_q  <= beat_q + ONE;
            count_q <= next_d;
            if (clip_d) sat_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign count = count_q;
  assign done  = done_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_mode_code_sequencer.sv
// Scoreboard bench for mode_code_sequencer at WIDTH=4: driver pushes the
// expected beat/done events, a negedge monitor pops and compares them.
module tb_mode_code_sequencer;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         reset;
  logic [2:0]   mode;
  logic         start;
  logic [W-1:0] len;
  logic         busy;
  logic         valid;
  logic [W-1:0] count;
  logic         done;
  logic         sat;

  mode_code_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .start (start),
    .len   (len),
    .busy  (busy),
    .valid (valid),
    .count (count),
    .done  (done),
    .sat   (sat)
  );

  typedef struct {
    int cyc;
    bit is_done;
    int cnt;
    bit sat;
  } item_t;

  item_t exp_q[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: beat values from the arithmetic rules on plain integers.
  task automatic push_run(input int n, input logic [2:0] m, input int l,
                          input int keep);
    int v;
    int s;
    bit st;
    item_t it;
    v  = m[2] ? 0 : MAXV;
    s  = m[1] ? 2 : 1;
    st = 0;
    for (int k = 0; k < l; k++) begin
      if (k > 0) begin
        v = m[2] ? v + s : v - s;
        if (m[0]) begin
          v = v & MAXV;
        end else if (v > MAXV) begin
          v  = MAXV;
          st = 1;
        end else if (v < 0) begin
          v  = 0;
          st = 1;
        end
      end
      if (k < keep) begin
        it.cyc = n + k; it.is_done = 0; it.cnt = v; it.sat = st;
        exp_q.push_back(it);
      end
    end
    if (keep >= l) begin
      it.cyc = n + l; it.is_done = 1; it.cnt = 0; it.sat = st;
      exp_q.push_back(it);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (valid || done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d valid=%b done=%b count=%0d",
                 cyc, valid, done, count);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.is_done != done || valid == e.is_done ||
            !busy || e.sat != sat || (!e.is_done && e.cnt != count)) begin
          errors++;
          $display("FAIL %s got cyc=%0d v=%b d=%b b=%b cnt=%0d sat=%b exp cyc=%0d d=%b cnt=%0d sat=%b",
                   e.is_done ? "done_evt" : "beat_evt", cyc, valid, done,
                   busy, count, sat, e.cyc, e.is_done, e.cnt, e.sat);
        end
      end
    end
  end

  // Called at a negedge while the DUT idles; returns at the idle negedge.
  task automatic run(input logic [2:0] m, input int l, input bit noise);
    int n;
    mode  = m;
    len   = W'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    push_run(n, m, l, l);
    do begin
      if (noise) begin
        start = 1'($urandom);
        mode  = 3'($urandom);
        len   = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end while (cyc < n + l + 1);
  endtask

  task automatic gap(input int c);
    start = 1'b0;
    for (int i = 0; i < c; i++) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== '0 ||
        done !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL %s got b=%b v=%b cnt=%0d d=%b sat=%b exp all 0",
               name, busy, valid, count, done, sat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    mode  = '0;
    len   = '0;
    #1;
    check_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run(3'b100, 3, 0);
    run(3'b111, 10, 0);
    run(3'b110, 10, 0);
    run(3'b001, 3, 1);
    run(3'b000, 15, 0);
    gap(2);
    run(3'b010, 10, 0);
    run(3'b011, 0, 0);
    run(3'b101, 0, 1);
    run(3'b100, 6, 1);
    gap(1);

    // Async reset on beat 2 of an 8-beat run.
    mode  = 3'b100;
    len   = W'(8);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    start = 1'b0;
    push_run(n, 3'b100, 8, 3);
    while (cyc < n + 2) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("async_reset_mid_run");
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got %0d exp 0", exp_q.size());
      exp_q.delete();
    end
    run(3'b100, 2, 0);

    for (int i = 0; i < 30; i++) begin
      run(3'($urandom), $urandom_range(0, MAXV), 1'($urandom));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
    end

    gap(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d left exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
